// File: rtl/imem_loader.sv
// Boot loader: zero-fills instruction memory, then writes a length-prefixed little-endian byte image
// word by word and releases the core on start_o once every header-counted byte has been consumed.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [15:0]       word_count_o
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_HEADER = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       DEPTH_N   = 16'(DEPTH);

  logic [2:0]  state, state_nxt;
  logic [1:0]  bcnt;
  logic [7:0]  hdr_lo;
  logic [23:0] shift_q;
  logic [15:0] nw_q;
  logic [17:0] drain_cnt;
  logic        take, last_word;
  logic [15:0] hdr_n, hdr_nw;

  assign take      = byte_valid_i & byte_ready_o;
  assign hdr_n     = {byte_data_i, hdr_lo};
  assign hdr_nw    = (hdr_n > DEPTH_N) ? DEPTH_N : hdr_n;
  assign last_word = (word_count_o + 16'd1) == nw_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (load_req_i) state_nxt = S_CLEAR;
      S_CLEAR:  if (wr_addr_o == LAST_ADDR) state_nxt = S_HEADER;
      S_HEADER: begin
        if (take && bcnt[0]) begin
          if (hdr_n == 16'd0)       state_nxt = S_RUN;
          else if (hdr_nw != 16'd0) state_nxt = S_LOAD;
          else                      state_nxt = S_DRAIN;
        end
      end
      S_LOAD:   if (take && bcnt == 2'd3 && last_word)
                  state_nxt = (drain_cnt != 18'd0) ? S_DRAIN : S_RUN;
      S_DRAIN:  if (take && drain_cnt == 18'd1) state_nxt = S_RUN;
      S_RUN:    if (load_req_i) state_nxt = S_CLEAR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      byte_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      start_o      <= 1'b0;
      err_o        <= 1'b0;
      word_count_o <= '0;
      bcnt         <= '0;
      hdr_lo       <= '0;
      shift_q      <= '0;
      nw_q         <= '0;
      drain_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      byte_ready_o <= (state_nxt == S_HEADER) || (state_nxt == S_LOAD) || (state_nxt == S_DRAIN);
      busy_o       <= (state_nxt == S_CLEAR) || (state_nxt == S_HEADER) ||
                      (state_nxt == S_LOAD) || (state_nxt == S_DRAIN);
      wr_en_o      <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (load_req_i) begin
            // First clear write is issued on the same edge that samples the request.
            wr_en_o      <= 1'b1;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            start_o      <= 1'b0;
            err_o        <= 1'b0;
            word_count_o <= '0;
            bcnt         <= '0;
          end else if (state == S_RUN) begin
            start_o <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (wr_addr_o != LAST_ADDR) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= wr_addr_o + ADDR_W'(1);
          end
        end
        S_HEADER: begin
          if (take) begin
            if (!bcnt[0]) begin
              hdr_lo <= byte_data_i;
              bcnt   <= 2'd1;
            end else begin
              nw_q      <= hdr_nw;
              err_o     <= hdr_n > DEPTH_N;
              drain_cnt <= {hdr_n - hdr_nw, 2'b00};
              bcnt      <= 2'd0;
              if (hdr_n == 16'd0) start_o <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (take) begin
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              wr_en_o      <= 1'b1;
              wr_addr_o    <= word_count_o[ADDR_W-1:0];
              wr_data_o    <= {byte_data_i, shift_q};
              word_count_o <= word_count_o + 16'd1;
            end else begin
              shift_q <= {byte_data_i, shift_q[23:8]};
            end
          end
        end
        S_DRAIN: begin
          if (take) begin
            drain_cnt <= drain_cnt - 18'd1;
            if (drain_cnt == 18'd1) start_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset abort, normal load, stalled source, oversize header, N=0, reload.
module tb_imem_loader;
  logic        clk_i = 1'b0;
  logic        rst_i, load_req_i, byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o, wr_en_o, start_o, busy_o, err_o;
  logic [7:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [15:0] word_count_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_req_i(load_req_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .start_o(start_o), .busy_o(busy_o), .err_o(err_o), .word_count_o(word_count_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (!rst_i && wr_en_o) begin
      wq_addr.push_back(wr_addr_o);
      wq_data.push_back(wr_data_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic pulse_req();
    load_req_i = 1'b1;
    @(negedge clk_i);
    load_req_i = 1'b0;
  endtask

  // Returns at the negedge following the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    while (!done && guard < 1000) begin
      if (rnd && ($urandom_range(1, 0) == 0)) begin
        byte_valid_i = 1'b0;
      end else begin
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        done         = byte_ready_o;
      end
      @(negedge clk_i);
      guard++;
    end
    byte_valid_i = 1'b0;
    if (!done) chk("byte_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], rnd);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    chk({tag, "_addr"},  32'(wr_addr_o), 32'd0);
    chk({tag, "_data"},  wr_data_o, 32'd0);
    chk({tag, "_start"}, 32'(start_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_err"},   32'(err_o), 32'd0);
    chk({tag, "_wc"},    32'(word_count_o), 32'd0);
  endtask

  task automatic chk_clear(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= wq_addr.size()) bad++;
      else if (wq_addr[i] !== 8'(i) || wq_data[i] !== 32'd0) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic run_small_image(input string tag, input bit rnd);
    send_byte(8'h02, rnd);
    send_byte(8'h00, rnd);
    send_word(32'h00500513, rnd);
    send_word(32'h000000B3, rnd);
    chk({tag, "_last_wr_en"}, 32'(wr_en_o), 32'd1);
    chk({tag, "_last_addr"}, 32'(wr_addr_o), 32'd1);
    chk({tag, "_start_not_yet"}, 32'(start_o), 32'd0);
    cyc();
    chk({tag, "_start"}, 32'(start_o), 32'd1);
    chk({tag, "_wc"}, 32'(word_count_o), 32'd2);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_nwrites"}, 32'(wq_addr.size()), 32'd258);
    chk_clear({tag, "_clear"});
    if (wq_addr.size() == 258) begin
      chk({tag, "_w0_addr"}, 32'(wq_addr[256]), 32'd0);
      chk({tag, "_w0_data"}, wq_data[256], 32'h00500513);
      chk({tag, "_w1_addr"}, 32'(wq_addr[257]), 32'd1);
      chk({tag, "_w1_data"}, wq_data[257], 32'h000000B3);
    end
  endtask

  initial begin
    int guard;
    int bad;
    logic [31:0] w;
    rst_i = 1'b1;
    load_req_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i = 8'h00;
    cyc();
    cyc();
    chk_reset_vals("reset");
    rst_i = 1'b0;
    cyc();

    // Reset mid-CLEAR
    pulse_req();
    chk("clear_first_wr_en", 32'(wr_en_o), 32'd1);
    chk("clear_first_addr", 32'(wr_addr_o), 32'd0);
    chk("clear_busy", 32'(busy_o), 32'd1);
    chk("clear_not_ready", 32'(byte_ready_o), 32'd0);
    guard = 0;
    while (wr_addr_o != 8'd100 && guard < 300) begin
      cyc();
      guard++;
    end
    chk("clear_reach_100", 32'(wr_addr_o), 32'd100);
    #2 rst_i = 1'b1;
    #1 chk_reset_vals("midclear_rst");
    wq_addr.delete();
    wq_data.delete();
    cyc();
    rst_i = 1'b0;
    repeat (4) cyc();
    chk("post_rst_no_writes", 32'(wq_addr.size()), 32'd0);
    chk("post_rst_idle_busy", 32'(busy_o), 32'd0);

    // Restart from address 0 and load the two-word image at full rate
    pulse_req();
    chk("restart_addr", 32'(wr_addr_o), 32'd0);
    chk("restart_wr_en", 32'(wr_en_o), 32'd1);
    run_small_image("full", 1'b0);

    // Reload from RUN with a stalling source
    wq_addr.delete();
    wq_data.delete();
    pulse_req();
    chk("reload_start_fall", 32'(start_o), 32'd0);
    chk("reload_wc_clear", 32'(word_count_o), 32'd0);
    chk("reload_addr0", 32'(wr_addr_o), 32'd0);
    run_small_image("stall", 1'b1);

    // Oversize header: N = 258
    wq_addr.delete();
    wq_data.delete();
    pulse_req();
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("big_err_early", 32'(err_o), 32'd1);
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(i * 4 + j);
      send_word(w, 1'b0);
    end
    chk("big_last_wr_en", 32'(wr_en_o), 32'd1);
    chk("big_last_addr", 32'(wr_addr_o), 32'd255);
    chk("big_last_data", wr_data_o, 32'hFFFEFDFC);
    chk("big_drain_ready", 32'(byte_ready_o), 32'd1);
    chk("big_drain_no_start", 32'(start_o), 32'd0);
    for (int k = 0; k < 8; k++) send_byte(8'hEE, 1'b0);
    chk("big_start", 32'(start_o), 32'd1);
    chk("big_err", 32'(err_o), 32'd1);
    chk("big_wc", 32'(word_count_o), 32'd256);
    chk("big_busy", 32'(busy_o), 32'd0);
    chk("big_nwrites", 32'(wq_addr.size()), 32'd512);
    if (wq_addr.size() == 512) begin
      chk("big_w0", wq_data[256], 32'h03020100);
      chk("big_w1", wq_data[257], 32'h07060504);
      bad = 0;
      for (int i = 0; i < 256; i++) if (wq_addr[256 + i] !== 8'(i)) bad++;
      chk("big_addr_seq", 32'(bad), 32'd0);
    end

    // Reload clears err; then header N = 0
    wq_addr.delete();
    wq_data.delete();
    pulse_req();
    chk("reload_err_clear", 32'(err_o), 32'd0);
    chk("reload2_wc_clear", 32'(word_count_o), 32'd0);
    chk("reload2_start_fall", 32'(start_o), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("n0_start", 32'(start_o), 32'd1);
    chk("n0_err", 32'(err_o), 32'd0);
    chk("n0_busy", 32'(busy_o), 32'd0);
    repeat (3) cyc();
    chk("n0_nwrites", 32'(wq_addr.size()), 32'd256);

    // load_req during LOAD is ignored
    wq_addr.delete();
    wq_data.delete();
    pulse_req();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    pulse_req();
    chk("ign_busy", 32'(busy_o), 32'd1);
    chk("ign_ready", 32'(byte_ready_o), 32'd1);
    chk("ign_wr_en", 32'(wr_en_o), 32'd0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("ign_wr_addr", 32'(wr_addr_o), 32'd0);
    chk("ign_wr_data", wr_data_o, 32'h00500513);
    chk("ign_wc", 32'(word_count_o), 32'd1);
    cyc();
    chk("ign_start", 32'(start_o), 32'd1);
    chk("ign_nwrites", 32'(wq_addr.size()), 32'd257);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
